signature_dumper: RTL and testbench

SIGNATURE_DUMPER -- requirements
Module: signature_dumper

---
 rtl/signature_dumper_if.sv | 35 +++
 rtl/signature_dumper.sv | 177 +++++++++++++++++
 tb/tb_signature_dumper.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/signature_dumper_if.sv
// Snoop, memory-read and signature-stream signals of signature_dumper.
// master = the dumper, slave = core/memory/consumer side.
interface signature_dumper_if;
   logic        snoop_wr;
   logic [31:0] snoop_addr;
   logic [31:0] snoop_wdata;
   logic [3:0]  snoop_wstrb;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   logic        sig_valid;
   logic        sig_ready;
   logic [31:0] sig_data;
   logic [15:0] sig_idx;

   modport master (
      input  snoop_wr, snoop_addr, snoop_wdata, snoop_wstrb,
      output mem_req, mem_addr,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output sig_valid, sig_data, sig_idx,
      input  sig_ready
   );

   modport slave (
      output snoop_wr, snoop_addr, snoop_wdata, snoop_wstrb,
      input  mem_req, mem_addr,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  sig_valid, sig_data, sig_idx,
      output sig_ready
   );
endinterface

// File: rtl/signature_dumper.sv
// Snoops core stores to the begin/end signature pointers, then reads and streams the
// signature words. Optional CRC-32 over streamed words when SIG_DUMP_CRC_EN is defined.
module signature_dumper #(
   parameter logic [31:0] BEGIN_PTR = 32'h0000_3FF0,
   parameter logic [31:0] END_PTR   = 32'h0000_3FF4,
   parameter int unsigned MIN_BEGIN = 16
) (
   input  logic                clk,
   input  logic                rst_b,
   signature_dumper_if.master  bus,
   output logic                done,
   output logic                err
`ifdef SIG_DUMP_CRC_EN
   ,
   output logic [31:0]         crc
`endif
);

   localparam int unsigned AW = 32;
   localparam int unsigned IW = 16;
   localparam logic [AW-1:0] WORD_MASK = 32'hFFFF_FFFC;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SEND, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] begin_q, begin_d;
   logic [AW-1:0] end_q, end_d;
   logic          mem_req_q, mem_req_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic          sig_valid_q, sig_valid_d;
   logic [31:0]   sig_data_q, sig_data_d;
   logic [IW-1:0] sig_idx_q, sig_idx_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   // Pointer writes only count as full-word stores while idle
   logic          full_wr_c, begin_wr_c, end_wr_c, legal_c, last_c;
   logic [AW-1:0] end_wdata_c, next_addr_c;

   assign full_wr_c   = bus.snoop_wr && (bus.snoop_wstrb == 4'hF) && (state_q == S_IDLE);
   assign begin_wr_c  = full_wr_c && (bus.snoop_addr == BEGIN_PTR);
   assign end_wr_c    = full_wr_c && (bus.snoop_addr == END_PTR);
   assign end_wdata_c = bus.snoop_wdata & WORD_MASK;
   assign legal_c     = (end_wdata_c > begin_q) && (begin_q > AW'(MIN_BEGIN));
   assign next_addr_c = mem_addr_q + AW'(4);
   assign last_c      = (next_addr_c >= end_q);

`ifdef SIG_DUMP_CRC_EN
   logic [31:0] crc_q, crc_d;

   // Reflected CRC-32, bit 0 of the word first (i.e. LSB byte first)
   function automatic logic [31:0] crc32_word(input logic [31:0] c_in, input logic [31:0] d);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 32; i++) begin
         if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
         else             c = c >> 1;
      end
      return c;
   endfunction
`endif

   // State register
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (end_wr_c && legal_c) state_d = S_REQ;
         S_REQ:  if (bus.mem_gnt)         state_d = S_WAIT;
         S_WAIT: if (bus.mem_rvalid)      state_d = S_SEND;
         S_SEND: if (bus.sig_ready)       state_d = last_c ? S_DONE : S_REQ;
         S_DONE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values
   always_comb begin
      begin_d     = begin_q;
      end_d       = end_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      sig_valid_d = sig_valid_q;
      sig_data_d  = sig_data_q;
      sig_idx_d   = sig_idx_q;
      done_d      = done_q;
      err_d       = err_q;
`ifdef SIG_DUMP_CRC_EN
      crc_d       = crc_q;
`endif
      if (begin_wr_c) begin_d = bus.snoop_wdata & WORD_MASK;
      case (state_q)
         S_IDLE: begin
            if (end_wr_c) begin
               if (legal_c) begin
                  end_d      = end_wdata_c;
                  mem_req_d  = 1'b1;
                  mem_addr_d = begin_q;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_REQ: if (bus.mem_gnt) mem_req_d = 1'b0;
         S_WAIT: begin
            if (bus.mem_rvalid) begin
               sig_valid_d = 1'b1;
               sig_data_d  = bus.mem_rdata;
            end
         end
         S_SEND: begin
            if (bus.sig_ready) begin
               sig_valid_d = 1'b0;
               sig_idx_d   = sig_idx_q + IW'(1);
`ifdef SIG_DUMP_CRC_EN
               crc_d       = crc32_word(crc_q, sig_data_q);
`endif
               if (last_c) begin
                  done_d = 1'b1;
               end else begin
                  mem_req_d  = 1'b1;
                  mem_addr_d = next_addr_c;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         begin_q     <= '0;
         end_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         sig_valid_q <= 1'b0;
         sig_data_q  <= '0;
         sig_idx_q   <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef SIG_DUMP_CRC_EN
         crc_q       <= 32'hFFFF_FFFF;
`endif
      end else begin
         begin_q     <= begin_d;
         end_q       <= end_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         sig_valid_q <= sig_valid_d;
         sig_data_q  <= sig_data_d;
         sig_idx_q   <= sig_idx_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef SIG_DUMP_CRC_EN
         crc_q       <= crc_d;
`endif
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.sig_valid = sig_valid_q;
   assign bus.sig_data  = sig_data_q;
   assign bus.sig_idx   = sig_idx_q;
   assign done          = done_q;
   assign err           = err_q;
`ifdef SIG_DUMP_CRC_EN
   assign crc           = crc_q;
`endif

endmodule

// File: tb/tb_signature_dumper.sv
// Randomized bench for signature_dumper against a queue-based reference model.
module tb_signature_dumper;
   localparam logic [31:0] BEGIN_PTR = 32'h0000_3FF0;
   localparam logic [31:0] END_PTR   = 32'h0000_3FF4;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic done, err;
`ifdef SIG_DUMP_CRC_EN
   logic [31:0] crc;
   logic [31:0] crc_m = 32'hFFFF_FFFF;
`endif

   signature_dumper_if bus ();

   signature_dumper dut (
      .clk(clk), .rst_b(rst_b), .bus(bus), .done(done), .err(err)
`ifdef SIG_DUMP_CRC_EN
      , .crc(crc)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic [15:0] idx;
   } exp_t;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_begin = '0;
   bit m_started = 0, m_err = 0, m_done = 0;
   exp_t exp_q[$];
   logic [31:0] addr_q[$];
   logic [31:0] log_data[$];
   logic [15:0] log_idx[$];
   int stall_seen = 0;

   // stimulus knobs
   int ready_mode = 0, stall_left = 0, gnt_wait = -1, rv_wait = -1;
   bit spur_en = 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

`ifdef SIG_DUMP_CRC_EN
   function automatic logic [31:0] crc_bytes(input logic [31:0] c_in, input logic [31:0] w);
      logic [31:0] c;
      logic [7:0] b;
      c = c_in;
      for (int k = 0; k < 4; k++) begin
         b = w[8*k +: 8];
         c = c ^ {24'h0, b};
         for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] log_at(input int i);
      if (i < log_data.size()) return log_data[i];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [15:0] idx_at(input int i);
      if (i < log_idx.size()) return log_idx[i];
      return 16'hDEAD;
   endfunction

   // Drives one store; model decides before the DUT samples, err becomes visible after
   task automatic snoop_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] e;
      bit set_err;
      int k;
      set_err = 0;
      @(posedge clk); #1;
      bus.snoop_wr = 1'b1; bus.snoop_addr = a; bus.snoop_wdata = d; bus.snoop_wstrb = s;
      if (s == 4'hF && !m_started) begin
         if (a == BEGIN_PTR) m_begin = d & 32'hFFFF_FFFC;
         else if (a == END_PTR) begin
            e = d & 32'hFFFF_FFFC;
            if (e > m_begin && m_begin > 32'd16) begin
               m_started = 1;
               k = 0;
               for (logic [31:0] w = m_begin; w < e; w += 32'd4) begin
                  exp_q.push_back({mem_word(w), 16'(k)});
                  addr_q.push_back(w);
                  k++;
               end
            end else set_err = 1;
         end
      end
      @(posedge clk); #1;
      bus.snoop_wr = 1'b0;
      if (set_err) m_err = 1;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_b = 1'b0;
      #1;
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_sig_valid", 32'(bus.sig_valid), 0);
      chk("rst_sig_data", bus.sig_data, 0);
      chk("rst_sig_idx", 32'(bus.sig_idx), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
`ifdef SIG_DUMP_CRC_EN
      chk("rst_crc", crc, 32'hFFFF_FFFF);
      crc_m = 32'hFFFF_FFFF;
`endif
      m_begin = '0; m_started = 0; m_err = 0; m_done = 0;
      exp_q.delete(); addr_q.delete(); log_data.delete(); log_idx.delete();
      stall_seen = 0;
      repeat (2) @(posedge clk);
      #2 rst_b = 1'b1;
   endtask

   task automatic wait_done(input int max_cyc, input string name);
      int n;
      n = 0;
      while (!done && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk(name, 32'(done), 1);
   endtask

   // Memory responder and sig_ready driver
   initial begin
      int rs, req_cnt, rv_left;
      logic [31:0] cur;
      bit grant;
      rs = 0; req_cnt = 0; rv_left = 0; cur = '0;
      forever begin
         @(posedge clk); #1;
         bus.mem_gnt = 1'b0;
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata = $urandom;
         case (ready_mode)
            0: bus.sig_ready = 1'b1;
            1: bus.sig_ready = 1'($urandom_range(0, 1));
            default: begin
               if (stall_left > 0 && bus.sig_valid) begin
                  bus.sig_ready = 1'b0;
                  stall_left--;
               end else bus.sig_ready = 1'b1;
            end
         endcase
         if (!rst_b) req_cnt = 0;
         else if (rs == 0) begin
            if (bus.mem_req) begin
               if (addr_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL mem_req_unexpected: got mem_req=1 addr %h expected no request", bus.mem_addr);
               end else chk("mem_addr", bus.mem_addr, addr_q[0]);
               grant = (gnt_wait >= 0) ? (req_cnt == gnt_wait) : ($urandom_range(0, 2) == 0);
               if (grant) begin
                  bus.mem_gnt = 1'b1;
                  cur = (addr_q.size() > 0) ? addr_q.pop_front() : bus.mem_addr;
                  rv_left = (rv_wait >= 0) ? rv_wait : int'($urandom_range(0, 3));
                  rs = 1;
                  req_cnt = 0;
               end else req_cnt++;
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
               bus.mem_rvalid = 1'b1;
            end
         end else begin
            if (rv_left == 0) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata = mem_word(cur);
               rs = 0;
            end else rv_left--;
         end
      end
   end

   // Per-cycle compare against the model
   initial begin
      exp_t f;
      forever begin
         @(negedge clk);
         if (rst_b) begin
            chk("err", 32'(err), 32'(m_err));
            chk("done", 32'(done), 32'(m_done));
`ifdef SIG_DUMP_CRC_EN
            if (m_done) chk("crc", crc, crc_m);
`endif
            if (bus.sig_valid) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL sig_unexpected: got word %h idx %0d expected none", bus.sig_data, bus.sig_idx);
               end else begin
                  f = exp_q[0];
                  chk("sig_data", bus.sig_data, f.data);
                  chk("sig_idx", 32'(bus.sig_idx), 32'(f.idx));
               end
               if (bus.sig_ready) begin
                  log_data.push_back(bus.sig_data);
                  log_idx.push_back(bus.sig_idx);
`ifdef SIG_DUMP_CRC_EN
                  crc_m = crc_bytes(crc_m, bus.sig_data);
`endif
                  if (exp_q.size() > 0) begin
                     void'(exp_q.pop_front());
                     if (exp_q.size() == 0) m_done = 1;
                  end
               end else stall_seen++;
            end
         end
      end
   end

   initial begin
      logic [31:0] b, e;
      bus.snoop_wr = 1'b0; bus.snoop_addr = '0; bus.snoop_wdata = '0; bus.snoop_wstrb = '0;
      bus.sig_ready = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

      // three-word dump
      do_reset();
      @(negedge clk);
      chk("idle_mem_req", 32'(bus.mem_req), 0);
      ready_mode = 0;
      snoop_write(BEGIN_PTR, 32'h2000, 4'hF);
      snoop_write(END_PTR, 32'h200C, 4'hF);
      wait_done(200, "basic_done");
      chk("basic_w0", log_at(0), 32'h2000_DFFF);
      chk("basic_w1", log_at(1), 32'h2004_DFFB);
      chk("basic_w2", log_at(2), 32'h2008_DFF7);
      chk("basic_idx2", 32'(idx_at(2)), 2);
      chk("basic_cnt", 32'(log_data.size()), 3);
      chk("basic_err", 32'(err), 0);
      // pointer writes after completion are ignored
      snoop_write(BEGIN_PTR, 32'h0100, 4'hF);
      snoop_write(END_PTR, 32'h0000, 4'hF);
      repeat (5) @(negedge clk);
      chk("post_done_err", 32'(err), 0);

      // begin equal to minimum is illegal
      do_reset();
      snoop_write(BEGIN_PTR, 32'h0010, 4'hF);
      snoop_write(END_PTR, 32'h0020, 4'hF);
      repeat (10) @(negedge clk);
      chk("illegal_err", 32'(err), 1);
      chk("illegal_done", 32'(done), 0);

      // partial strobe ignored, unaligned end rounded down
      do_reset();
      snoop_write(BEGIN_PTR, 32'h3000, 4'hF);
      snoop_write(BEGIN_PTR, 32'h0100, 4'h3);
      snoop_write(END_PTR, 32'h300B, 4'hF);
      wait_done(200, "strb_done");
      chk("strb_cnt", 32'(log_data.size()), 2);
      chk("strb_w1", log_at(1), 32'h3004_CFFB);

      // smallest legal begin, one word
      do_reset();
      snoop_write(BEGIN_PTR, 32'h0014, 4'hF);
      snoop_write(END_PTR, 32'h0018, 4'hF);
      wait_done(200, "one_done");
      chk("one_w0", log_at(0), 32'h0014_FFEB);

      // consumer stall on the first word
      do_reset();
      ready_mode = 2; stall_left = 5;
      snoop_write(BEGIN_PTR, 32'h1000, 4'hF);
      snoop_write(END_PTR, 32'h1008, 4'hF);
      wait_done(200, "stall_done");
      chk("stall_cycles", 32'(stall_seen), 5);
      chk("stall_w0", log_at(0), 32'h1000_EFFF);
      chk("stall_w1", log_at(1), 32'h1004_EFFB);
      ready_mode = 0;

      // slow grant and read data
      do_reset();
      gnt_wait = 3; rv_wait = 1;
      snoop_write(BEGIN_PTR, 32'h0100, 4'hF);
      snoop_write(END_PTR, 32'h0104, 4'hF);
      wait_done(200, "slow_done");
      chk("slow_w0", log_at(0), 32'h0100_FEFF);
      gnt_wait = -1; rv_wait = -1;

      // reset mid-dump, then restart; pointer writes during the dump are ignored
      do_reset();
      snoop_write(BEGIN_PTR, 32'h0400, 4'hF);
      snoop_write(END_PTR, 32'h0410, 4'hF);
      snoop_write(END_PTR, 32'h0404, 4'hF);
      begin
         int n;
         n = 0;
         while (log_data.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk("mid_reached", 32'(log_data.size() >= 2), 1);
      end
      do_reset();
      snoop_write(BEGIN_PTR, 32'h0800, 4'hF);
      snoop_write(END_PTR, 32'h0808, 4'hF);
      wait_done(200, "restart_done");
      chk("restart_idx0", 32'(idx_at(0)), 0);
      chk("restart_w0", log_at(0), 32'h0800_F7FF);

      // randomized runs
      for (int it = 0; it < 16; it++) begin
         do_reset();
         ready_mode = int'($urandom_range(0, 1));
         b = $urandom_range(0, 48);
         e = $urandom_range(0, 80);
         snoop_write(BEGIN_PTR, b, 4'hF);
         if ($urandom_range(0, 3) == 0) snoop_write(BEGIN_PTR, $urandom, 4'($urandom_range(0, 14)));
         snoop_write(END_PTR, e, 4'hF);
         if (m_started) begin
            snoop_write(BEGIN_PTR, $urandom_range(20, 60), 4'hF);
            wait_done(800, "rand_done");
         end else repeat (8) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
